// File: rtl/l2_cacheline_adaptor.sv
// L2 line <-> memory burst adaptor: splits a buffered line write-back into beats and
// reassembles read beats into a line. Optional stall timeout enabled by CLA_TIMEOUT_EN.
module l2_cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
`ifdef CLA_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [31:0]        line_addr_i,
    input  logic [s_line-1:0]  line_wdata_i,
    output logic [s_line-1:0]  line_rdata_o,
    output logic               line_resp_o,
    output logic               pmem_read_o,
    output logic               pmem_write_o,
    output logic [31:0]        pmem_addr_o,
    output logic [s_burst-1:0] pmem_wdata_o,
    input  logic [s_burst-1:0] pmem_rdata_i,
    input  logic               pmem_resp_i
`ifdef CLA_TIMEOUT_EN
    ,
    output logic               timeout_err_o
`endif
);

    localparam int BEATS = s_line / s_burst;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(s_line / 8);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        addr_reg;
    logic [s_burst-1:0] wbuf_reg [BEATS];
    logic [s_burst-1:0] rbuf_reg [BEATS];
    logic               accept_wr, accept_rd, in_burst, force_done;

    assign in_burst = (state_reg == RD_BURST) || (state_reg == WR_BURST);

`ifdef CLA_TIMEOUT_EN
    localparam int TMO_W = $clog2(timeout_cycles + 1);
    logic [TMO_W-1:0] tmo_reg;
    logic             err_reg;

    // Counts consecutive stalled burst cycles; any accepted beat restarts the window.
    assign force_done = in_burst && !pmem_resp_i && (tmo_reg == TMO_W'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (in_burst && !pmem_resp_i)
                tmo_reg <= tmo_reg + 1'b1;
            else
                tmo_reg <= '0;
            if (force_done)
                err_reg <= 1'b1;
        end
    end

    assign timeout_err_o = err_reg;
`else
    assign force_done = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (line_write_i) begin
                    accept_wr  = 1'b1;
                    state_next = WR_BURST;
                end else if (line_read_i) begin
                    accept_rd  = 1'b1;
                    state_next = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                // Counter holds on the last beat so it never wraps mid-line.
                if (pmem_resp_i) begin
                    if (cnt_reg == LAST_BEAT)
                        state_next = DONE;
                    else
                        cnt_next = cnt_reg + 1'b1;
                end else if (force_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept_wr || accept_rd)
                addr_reg <= line_addr_i & ADDR_MASK;
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            always_ff @(posedge clk) begin
                if (rst)
                    wbuf_reg[gi] <= '0;
                else if (accept_wr)
                    wbuf_reg[gi] <= line_wdata_i[gi*s_burst +: s_burst];
            end

            always_ff @(posedge clk) begin
                if (rst)
                    rbuf_reg[gi] <= '0;
                else if ((state_reg == RD_BURST) && pmem_resp_i && (cnt_reg == CNT_W'(gi)))
                    rbuf_reg[gi] <= pmem_rdata_i;
            end

            assign line_rdata_o[gi*s_burst +: s_burst] = rbuf_reg[gi];
        end
    endgenerate

    assign pmem_read_o  = (state_reg == RD_BURST);
    assign pmem_write_o = (state_reg == WR_BURST);
    assign line_resp_o  = (state_reg == DONE);
    assign pmem_addr_o  = addr_reg;
    assign pmem_wdata_o = wbuf_reg[cnt_reg];

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed bench for l2_cacheline_adaptor: read refill, gapped read, write-back,
// simultaneous requests, mid-burst reset and (with CLA_TIMEOUT_EN) stall timeout.
module tb_l2_cacheline_adaptor;

    localparam int S_LINE  = 256;
    localparam int S_BURST = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               line_read_i, line_write_i;
    logic [31:0]        line_addr_i;
    logic [S_LINE-1:0]  line_wdata_i;
    logic [S_LINE-1:0]  line_rdata_o;
    logic               line_resp_o;
    logic               pmem_read_o, pmem_write_o;
    logic [31:0]        pmem_addr_o;
    logic [S_BURST-1:0] pmem_wdata_o;
    logic [S_BURST-1:0] pmem_rdata_i;
    logic               pmem_resp_i;
`ifdef CLA_TIMEOUT_EN
    logic               timeout_err_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_cacheline_adaptor #(
        .s_line (S_LINE),
        .s_burst(S_BURST)
`ifdef CLA_TIMEOUT_EN
        ,
        .timeout_cycles(16)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_read_i  (line_read_i),
        .line_write_i (line_write_i),
        .line_addr_i  (line_addr_i),
        .line_wdata_i (line_wdata_i),
        .line_rdata_o (line_rdata_o),
        .line_resp_o  (line_resp_o),
        .pmem_read_o  (pmem_read_o),
        .pmem_write_o (pmem_write_o),
        .pmem_addr_o  (pmem_addr_o),
        .pmem_wdata_o (pmem_wdata_o),
        .pmem_rdata_i (pmem_rdata_i),
        .pmem_resp_i  (pmem_resp_i)
`ifdef CLA_TIMEOUT_EN
        ,
        .timeout_err_o(timeout_err_o)
`endif
    );

    function automatic logic [S_BURST-1:0] beat_of(input int k);
        return 64'(k) * 64'h0101_0101_0101_0101;
    endfunction

    logic [S_LINE-1:0] gaps_line;

    task automatic test_reset();
        rst = 1'b1; line_read_i = 0; line_write_i = 0; line_addr_i = '0;
        line_wdata_i = '0; pmem_rdata_i = '0; pmem_resp_i = 0;
        repeat (2) @(negedge clk);
        checks++; if (pmem_read_o !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got %b want 0", pmem_read_o); end
        checks++; if (pmem_write_o !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got %b want 0", pmem_write_o); end
        checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL reset_line_resp got %b want 0", line_resp_o); end
        checks++; if (pmem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_pmem_addr got %h want 0", pmem_addr_o); end
        checks++; if (pmem_wdata_o !== 64'h0) begin failures++; $display("FAIL reset_pmem_wdata got %h want 0", pmem_wdata_o); end
        checks++; if (line_rdata_o !== '0) begin failures++; $display("FAIL reset_line_rdata got %h want 0", line_rdata_o); end
`ifdef CLA_TIMEOUT_EN
        checks++; if (timeout_err_o !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got %b want 0", timeout_err_o); end
`endif
        rst = 1'b0;
        // A stray memory response in IDLE must not be captured.
        pmem_resp_i = 1; pmem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        pmem_resp_i = 0;
        @(negedge clk);
        checks++; if (line_rdata_o !== '0) begin failures++; $display("FAIL idle_resp_ignored got %h want 0", line_rdata_o); end
        checks++; if (pmem_read_o !== 1'b0) begin failures++; $display("FAIL idle_no_read got %b want 0", pmem_read_o); end
        $display("txn reset done");
    endtask

    task automatic test_read_refill();
        logic [S_BURST-1:0] bt [4];
        logic [S_LINE-1:0]  exp_line;
        bt[0] = {8{8'hA0}}; bt[1] = {8{8'hB1}}; bt[2] = {8{8'hC2}}; bt[3] = {8{8'hD3}};
        exp_line = {bt[3], bt[2], bt[1], bt[0]};
        @(negedge clk);
        line_read_i = 1; line_addr_i = 32'h0000_1234;
        @(negedge clk);
        checks++; if (pmem_read_o !== 1'b1) begin failures++; $display("FAIL refill_pmem_read got %b want 1", pmem_read_o); end
        checks++; if (pmem_addr_o !== 32'h0000_1220) begin failures++; $display("FAIL refill_addr got %h want 00001220", pmem_addr_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL refill_early_resp beat %0d got %b want 0", i, line_resp_o); end
            pmem_resp_i = 1; pmem_rdata_i = bt[i];
            @(negedge clk);
        end
        pmem_resp_i = 0;
        checks++; if (line_resp_o !== 1'b1) begin failures++; $display("FAIL refill_resp got %b want 1", line_resp_o); end
        checks++; if (line_rdata_o !== exp_line) begin failures++; $display("FAIL refill_line got %h want %h", line_rdata_o, exp_line); end
        line_read_i = 0;
        @(negedge clk);
        checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL refill_resp_once got %b want 0", line_resp_o); end
        checks++; if (pmem_read_o !== 1'b0) begin failures++; $display("FAIL refill_read_drop got %b want 0", pmem_read_o); end
        checks++; if (line_rdata_o !== exp_line) begin failures++; $display("FAIL refill_line_hold got %h want %h", line_rdata_o, exp_line); end
        $display("txn read_refill addr=00001234 line=%h", line_rdata_o);
    endtask

    task automatic test_read_gaps();
        gaps_line = {beat_of(10), beat_of(6), beat_of(5), beat_of(2)};
        @(negedge clk);
        line_read_i = 1; line_addr_i = 32'h0000_1234; pmem_resp_i = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            checks++; if (line_resp_o !== (k == 11)) begin failures++; $display("FAIL gaps_resp cycle %0d got %b want %b", k, line_resp_o, (k == 11)); end
            if (k <= 10) begin
                checks++; if (pmem_read_o !== 1'b1) begin failures++; $display("FAIL gaps_pmem_read cycle %0d got %b want 1", k, pmem_read_o); end
                pmem_resp_i  = (k == 2 || k == 5 || k == 6 || k == 10);
                pmem_rdata_i = beat_of(k);
            end else begin
                checks++; if (line_rdata_o !== gaps_line) begin failures++; $display("FAIL gaps_line got %h want %h", line_rdata_o, gaps_line); end
                line_read_i = 0; pmem_resp_i = 0;
            end
        end
        @(negedge clk);
        checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL gaps_resp_once got %b want 0", line_resp_o); end
        checks++; if (line_rdata_o !== gaps_line) begin failures++; $display("FAIL gaps_no_extra got %h want %h", line_rdata_o, gaps_line); end
        $display("txn read_gaps line=%h", line_rdata_o);
    endtask

    task automatic test_write_back();
        logic [S_BURST-1:0] exp_beat;
        @(negedge clk);
        line_write_i = 1; line_addr_i = 32'h8000_00FF;
        line_wdata_i = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                        64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
        @(negedge clk);
        checks++; if (pmem_write_o !== 1'b1) begin failures++; $display("FAIL wb_pmem_write got %b want 1", pmem_write_o); end
        checks++; if (pmem_read_o !== 1'b0) begin failures++; $display("FAIL wb_no_read got %b want 0", pmem_read_o); end
        line_addr_i = 32'h0; line_wdata_i = '1;
        for (int i = 0; i < 4; i++) begin
            exp_beat = 64'(i) * 64'h1111_1111_1111_1111;
            checks++; if (pmem_wdata_o !== exp_beat) begin failures++; $display("FAIL wb_beat %0d got %h want %h", i, pmem_wdata_o, exp_beat); end
            checks++; if (pmem_addr_o !== 32'h8000_00E0) begin failures++; $display("FAIL wb_addr beat %0d got %h want 800000e0", i, pmem_addr_o); end
            pmem_resp_i = 1;
            @(negedge clk);
        end
        pmem_resp_i = 0;
        checks++; if (line_resp_o !== 1'b1) begin failures++; $display("FAIL wb_resp got %b want 1", line_resp_o); end
        checks++; if (line_rdata_o !== gaps_line) begin failures++; $display("FAIL wb_rdata_kept got %h want %h", line_rdata_o, gaps_line); end
        line_write_i = 0;
        @(negedge clk);
        checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL wb_resp_once got %b want 0", line_resp_o); end
        checks++; if (pmem_write_o !== 1'b0) begin failures++; $display("FAIL wb_write_drop got %b want 0", pmem_write_o); end
        $display("txn write_back addr=800000ff");
    endtask

    task automatic test_back_to_back();
        int resp_n = 0, first_wr = -1, first_rd = -1;
        int resp_c [2];
        logic [S_LINE-1:0] exp_line;
        resp_c[0] = -1; resp_c[1] = -1;
        exp_line = {beat_of(10), beat_of(9), beat_of(8), beat_of(7)};
        @(negedge clk);
        line_read_i = 1; line_write_i = 1; line_addr_i = 32'h0000_0040;
        line_wdata_i = {4{64'h5A5A_5A5A_5A5A_5A5A}}; pmem_resp_i = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            pmem_rdata_i = beat_of(k);
            if (pmem_write_o && first_wr < 0) first_wr = k;
            if (pmem_read_o && first_rd < 0) first_rd = k;
            if (line_resp_o) begin
                if (resp_n < 2) resp_c[resp_n] = k;
                resp_n++;
                if (resp_n == 1) line_write_i = 0;
                else line_read_i = 0;
            end
        end
        pmem_resp_i = 0; line_read_i = 0; line_write_i = 0;
        checks++; if (resp_n !== 2) begin failures++; $display("FAIL b2b_resp_count got %0d want 2", resp_n); end
        checks++; if (first_wr !== 1) begin failures++; $display("FAIL b2b_write_first got cycle %0d want 1", first_wr); end
        checks++; if (first_rd !== 7) begin failures++; $display("FAIL b2b_read_start got cycle %0d want 7", first_rd); end
        checks++; if (resp_c[0] !== 5) begin failures++; $display("FAIL b2b_resp0 got cycle %0d want 5", resp_c[0]); end
        checks++; if (resp_c[1] !== 11) begin failures++; $display("FAIL b2b_resp1 got cycle %0d want 11", resp_c[1]); end
        checks++; if (line_rdata_o !== exp_line) begin failures++; $display("FAIL b2b_line got %h want %h", line_rdata_o, exp_line); end
        $display("txn back_to_back resp_cycles=%0d,%0d", resp_c[0], resp_c[1]);
    endtask

    task automatic test_reset_mid_burst();
        logic [S_LINE-1:0] exp_line;
        exp_line = {beat_of(8'h24), beat_of(8'h23), beat_of(8'h22), beat_of(8'h21)};
        @(negedge clk);
        line_read_i = 1; line_addr_i = 32'h0000_2000;
        @(negedge clk);
        pmem_resp_i = 1; pmem_rdata_i = beat_of(8'h11);
        @(negedge clk);
        pmem_rdata_i = beat_of(8'h12);
        @(negedge clk);
        rst = 1; pmem_resp_i = 0; line_read_i = 0;
        @(negedge clk);
        checks++; if (pmem_read_o !== 1'b0) begin failures++; $display("FAIL rstmid_read got %b want 0", pmem_read_o); end
        checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL rstmid_resp got %b want 0", line_resp_o); end
        checks++; if (line_rdata_o !== '0) begin failures++; $display("FAIL rstmid_line got %h want 0", line_rdata_o); end
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (line_resp_o !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp cycle %0d got %b want 0", k, line_resp_o); end
        end
        line_read_i = 1; line_addr_i = 32'h0000_3000;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pmem_resp_i = 1; pmem_rdata_i = beat_of(8'h21 + i);
            @(negedge clk);
        end
        pmem_resp_i = 0;
        checks++; if (line_resp_o !== 1'b1) begin failures++; $display("FAIL rstmid_new_resp got %b want 1", line_resp_o); end
        checks++; if (line_rdata_o !== exp_line) begin failures++; $display("FAIL rstmid_new_line got %h want %h", line_rdata_o, exp_line); end
        line_read_i = 0;
        @(negedge clk);
        $display("txn reset_mid_burst then read line=%h", line_rdata_o);
    endtask

`ifdef CLA_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        line_read_i = 1; line_addr_i = 32'h0000_0100; pmem_resp_i = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            checks++; if (line_resp_o !== (k == 17)) begin failures++; $display("FAIL tmo_resp cycle %0d got %b want %b", k, line_resp_o, (k == 17)); end
            checks++; if (timeout_err_o !== (k == 17)) begin failures++; $display("FAIL tmo_err cycle %0d got %b want %b", k, timeout_err_o, (k == 17)); end
        end
        line_read_i = 0;
        @(negedge clk);
        checks++; if (timeout_err_o !== 1'b1) begin failures++; $display("FAIL tmo_sticky got %b want 1", timeout_err_o); end
        checks++; if (pmem_read_o !== 1'b0) begin failures++; $display("FAIL tmo_idle got %b want 0", pmem_read_o); end
        $display("txn timeout err=%b", timeout_err_o);
    endtask
`endif

    initial begin
        test_reset();
        test_read_refill();
        test_read_gaps();
        test_write_back();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef CLA_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
